serial_bit_feeder: RTL and testbench

Parallel-to-serial front end for the Mealy sequence detector. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on x_out, which drives the detector's x input. A one-entry holding register is double-buffered with the shift register, so back-to-back words stream with no bubble. An optional idle gap can be inserted between words.

---
 rtl/feeder_pkg.sv | 7 +
 rtl/feeder_shift_reg.sv | 22 ++
 rtl/serial_bit_feeder.sv | 98 +++++++++
 tb/tb_serial_bit_feeder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/feeder_pkg.sv
// feeder_pkg: state encoding and parameter limits shared by serial_bit_feeder
package feeder_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_SHIFT = 2'b01, ST_GAP = 2'b10} state_e;
  localparam int MAX_WIDTH = 32;
  localparam int MAX_GAP = 15;
  localparam int GAP_W = 4;
endpackage

// File: rtl/feeder_shift_reg.sv
// feeder_shift_reg: parallel-load shift register presenting its outgoing bit
module feeder_shift_reg
  import feeder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             bit_out
);
  logic [WIDTH-1:0] sr_q, sr_d;
  always_comb sr_d = load ? d : shift ? (MSB_FIRST ? sr_q << 1 : sr_q >> 1) : sr_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sr_q <= '0;
    else sr_q <= sr_d;
  end
  assign bit_out = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
endmodule

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: double-buffered parallel-to-serial feeder for the sequence detector
module serial_bit_feeder
  import feeder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP_CYCLES = 0,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             enable,
  output logic             x_out,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);
  if (WIDTH < 2 || WIDTH > MAX_WIDTH || GAP_CYCLES < 0 || GAP_CYCLES > MAX_GAP) begin : g_bad_param
    $error("serial_bit_feeder: parameter out of range");
  end
  state_e state_q, state_d;
  logic hold_full_q, hold_full_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic xo_q, xo_d;
  logic load, shift, sh_bit, accept, last_bit;
  feeder_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_shift (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .shift  (shift),
    .d      (hold_q),
    .bit_out(sh_bit)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    gap_d = gap_q;
    load = 1'b0;
    x_valid = 1'b0;
    word_done = 1'b0;
    accept = in_valid & ~hold_full_q;
    last_bit = cnt_q == LAST_BIT;
    if (state_q == ST_SHIFT) begin
      x_valid = enable;
      word_done = enable & last_bit;
      if (enable) cnt_d = last_bit ? '0 : cnt_q + 1'b1;
      if (enable & last_bit) begin
        if (GAP_CYCLES > 0) begin
          state_d = ST_GAP;
          gap_d = '0;
        end else begin
          load = hold_full_q;
          state_d = hold_full_q ? ST_SHIFT : ST_IDLE;
        end
      end
    end else if (state_q == ST_GAP) begin
      if (enable) gap_d = gap_q + 1'b1;
      if (enable & (gap_q == LAST_GAP)) begin
        load = hold_full_q;
        state_d = hold_full_q ? ST_SHIFT : ST_IDLE;
      end
    end else begin
      load = hold_full_q & enable;
      state_d = load ? ST_SHIFT : ST_IDLE;
    end
    hold_full_d = (hold_full_q & ~load) | accept;
    hold_d = accept ? in_data : hold_q;
    shift = (state_q == ST_SHIFT) & enable;
    x_out = (state_q == ST_SHIFT) ? (enable ? sh_bit : xo_q) : 1'b0;
    xo_d = x_out;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      hold_full_q <= 1'b0;
      hold_q <= '0;
      cnt_q <= '0;
      gap_q <= '0;
      xo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_full_q <= hold_full_d;
      hold_q <= hold_d;
      cnt_q <= cnt_d;
      gap_q <= gap_d;
      xo_q <= xo_d;
    end
  end
  assign in_ready = ~hold_full_q;
  assign busy = (state_q != ST_IDLE) | hold_full_q;
endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder: three feeder configurations checked against a word-level model
module tb_serial_bit_feeder;
  localparam int W = 4;
  localparam int NI = 3;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [W-1:0] in_data = '0;
  logic [NI-1:0] in_valid = '0;
  logic enable = 1'b0;
  logic [NI-1:0] in_ready, x_out, x_valid, word_done, busy;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit clr = 1'b0;
  int rem [NI];
  int gl [NI];
  bit full [NI];
  bit prev [NI];
  logic [W-1:0] hold [NI];
  logic [W-1:0] cur [NI];
  int nb [NI];
  int wdc [NI];
  int run [NI];
  int max_run [NI];
  int first_cyc [NI];
  logic [31:0] sv [NI];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  serial_bit_feeder #(.WIDTH(W), .GAP_CYCLES(0), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .enable(enable), .x_out(x_out[0]), .x_valid(x_valid[0]), .word_done(word_done[0]), .busy(busy[0])
  );
  serial_bit_feeder #(.WIDTH(W), .GAP_CYCLES(3), .MSB_FIRST(1'b1)) u_b (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .enable(enable), .x_out(x_out[1]), .x_valid(x_valid[1]), .word_done(word_done[1]), .busy(busy[1])
  );
  serial_bit_feeder #(.WIDTH(W), .GAP_CYCLES(0), .MSB_FIRST(1'b0)) u_c (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .enable(enable), .x_out(x_out[2]), .x_valid(x_valid[2]), .word_done(word_done[2]), .busy(busy[2])
  );
  function automatic int gap_of(input int i);
    return i == 1 ? 3 : 0;
  endfunction
  function automatic bit msb_of(input int i);
    return i != 2;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    bit ev, eo, ew, eb, er, b, ld, old, acc;
    if (clr)
      for (int i = 0; i < NI; i++) begin
        nb[i] = 0; wdc[i] = 0; run[i] = 0; max_run[i] = 0; sv[i] = '0; first_cyc[i] = -1;
      end
    for (int i = 0; i < NI; i++) begin
      if (!reset) begin
        rem[i] = 0; gl[i] = 0; full[i] = 1'b0; prev[i] = 1'b0;
      end
      b = 1'b0;
      if (rem[i] > 0) b = msb_of(i) ? cur[i][rem[i]-1] : cur[i][W-rem[i]];
      ev = rem[i] > 0 && enable;
      eo = rem[i] > 0 ? (enable ? b : prev[i]) : 1'b0;
      ew = ev && rem[i] == 1;
      eb = rem[i] > 0 || gl[i] > 0 || full[i];
      er = !full[i];
      chk($sformatf("inst%0d {x_out,x_valid,word_done,busy,in_ready}", i),
          {x_out[i], x_valid[i], word_done[i], busy[i], in_ready[i]}, {eo, ev, ew, eb, er});
      if (reset) begin
        if (x_valid[i]) begin
          if (nb[i] == 0) first_cyc[i] = cyc;
          else if (run[i] > max_run[i]) max_run[i] = run[i];
          sv[i] = {sv[i][30:0], x_out[i]};
          nb[i]++;
          run[i] = 0;
        end else run[i]++;
        if (word_done[i]) wdc[i]++;
        old = full[i];
        acc = in_valid[i] && !old;
        ld = 1'b0;
        if (enable) begin
          if (rem[i] > 0) begin
            rem[i]--;
            if (rem[i] == 0) begin
              if (gap_of(i) > 0) gl[i] = gap_of(i);
              else ld = old;
            end
          end else if (gl[i] > 0) begin
            gl[i]--;
            ld = gl[i] == 0 && old;
          end else ld = old;
        end
        if (ld) begin
          cur[i] = hold[i]; rem[i] = W; full[i] = 1'b0;
        end
        if (acc) begin
          full[i] = 1'b1; hold[i] = in_data;
        end
        prev[i] = eo;
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_logs();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask
  task automatic offer(input logic [W-1:0] w, output int acc);
    logic [NI-1:0] pend, rdy;
    in_data = w;
    pend = '1;
    in_valid = pend;
    for (int k = 0; k < 100 && pend != 0; k++) begin
      @(negedge clk) rdy = in_ready;
      step();
      pend = pend & ~rdy;
      in_valid = pend;
    end
    acc = cyc;
    if (pend != 0) chk("offer timeout", 32'(pend), 0);
    in_valid = '0;
  endtask
  task automatic wait_nb(input int i, input int n);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(posedge clk);
      ok = nb[i] >= n;
    end
    #1;
    if (!ok) chk("wait bits timeout", nb[i], n);
  endtask
  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) @(negedge clk) ok = busy == '0;
    step();
    step();
    if (!ok) chk("drain timeout", 32'(busy), 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL global timeout");
    $fatal(1);
  end
  initial begin
    int acc;
    enable = 1'b1;
    repeat (3) step();
    chk("reset in_ready", 32'(in_ready), 32'h7);
    chk("reset busy", 32'(busy), 0);
    reset = 1'b1;
    step();
    clear_logs();
    offer(4'b1011, acc);
    chk("in_ready low while held", 32'(in_ready), 0);
    step();
    chk("in_ready back after load", 32'(in_ready), 32'h7);
    drain();
    chk("single word msb", sv[0], 32'hB);
    chk("single word bits", nb[0], 4);
    chk("single word lsb", sv[2], 32'hD);
    chk("single word done", wdc[0], 1);
    chk("latency", first_cyc[0] - acc + 1, 2);
    clear_logs();
    offer(4'b1011, acc);
    offer(4'b0110, acc);
    drain();
    chk("b2b stream", sv[0], 32'hB6);
    chk("b2b bits", nb[0], 8);
    chk("b2b done pulses", wdc[0], 2);
    chk("b2b no bubble", max_run[0], 0);
    chk("gap stream", sv[1], 32'hB6);
    chk("gap length", max_run[1], 3);
    chk("b2b lsb stream", sv[2], 32'hD6);
    clear_logs();
    offer(4'b1011, acc);
    wait_nb(0, 2);
    enable = 1'b0;
    in_data = 4'b0001;
    in_valid = '1;
    step();
    in_valid = '0;
    chk("accept while paused", 32'(in_ready), 0);
    repeat (4) step();
    enable = 1'b1;
    drain();
    chk("pause stream", sv[0], 32'hB1);
    chk("pause bits", nb[0], 8);
    chk("pause length", max_run[0], 5);
    chk("pause lsb stream", sv[2], 32'hD8);
    chk("pause done pulses", wdc[0], 2);
    clear_logs();
    offer(4'b1011, acc);
    wait_nb(0, 2);
    reset = 1'b0;
    #1;
    chk("async reset x_valid", 32'(x_valid), 0);
    chk("async reset busy", 32'(busy), 0);
    chk("async reset in_ready", 32'(in_ready), 32'h7);
    step();
    step();
    reset = 1'b1;
    clear_logs();
    offer(4'b0110, acc);
    drain();
    chk("post reset stream", sv[0], 32'h6);
    chk("post reset bits", nb[0], 4);
    chk("post reset done", wdc[0], 1);
    for (int n = 0; n < 2000; n++) begin
      in_data = W'($urandom);
      in_valid = NI'($urandom);
      enable = $urandom_range(0, 7) != 0;
      reset = $urandom_range(0, 149) != 0;
      step();
    end
    reset = 1'b1;
    enable = 1'b1;
    in_valid = '0;
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
